full_adder: RTL and testbench

- Single-bit full adder: sums a, b and cin, producing sum and carry.
- Combinational outputs (sum, carry) are valid within the same evaluation, with no clock edge required.
- A registered copy of the result (sum_q, carry_q, out_valid) is provided for pipelined consumers.
- Leaf arithmetic cell; used standalone and as the bit-slice for ripple-carry adders.

---
 rtl/full_adder.sv | 61 ++++++
 tb/tb_full_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Single-bit full adder with a zero-latency combinational result and a
// one-cycle registered copy qualified by out_valid.
module full_adder #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic in_valid,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q,
  output logic out_valid
);

  logic sum_d;
  logic carry_d;
  logic out_valid_d;
  logic out_valid_q;

  // Returns {carry, sum} = x + y + z as a 2-bit value.
  function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
    logic [1:0] res;
    res[0] = x ^ y ^ z;
    res[1] = (x & y) | (x & z) | (y & z);
    return res;
  endfunction

  always_comb begin
    {carry, sum} = add3(a, b, cin);
  end

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
    end
  end

  // Registered stage: holds the last captured result while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= RESET_VAL;
      carry_q     <= RESET_VAL;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: stimulus pushes expected {carry,sum} for
// every valid capture; a monitor pops and compares whenever out_valid is seen.
module tb_full_adder;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;
  logic out_valid;

  int n_vec;
  int n_fail;
  logic [1:0] exp_q[$];

  full_adder #(.RESET_VAL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .carry    (carry),
    .sum_q    (sum_q),
    .carry_q  (carry_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Monitor: every registered output qualified by out_valid must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: got {carry_q,sum_q}=%b, required no output", {carry_q, sum_q});
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({carry_q, sum_q} !== e) begin
          n_fail++;
          $display("FAIL reg_result: got {carry_q,sum_q}=%b, required %b", {carry_q, sum_q}, e);
        end
      end
    end
  end

  // Apply one input vector, queue its expectation if valid, advance one edge, check out_valid.
  task automatic issue(input logic v, input logic [2:0] abc);
    {a, b, cin} = abc;
    in_valid = v;
    if (v) exp_q.push_back({(abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]),
                            abc[2] ^ abc[1] ^ abc[0]});
    @(posedge clk);
    #1;
    check("out_valid_follow", {3'b0, out_valid}, {3'b0, v});
  endtask

  initial begin
    logic [1:0] comb_tab [8];
    comb_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    cin = 1'b0;
    in_valid = 1'b0;

    #7;
    check("reset_state", {1'b0, sum_q, carry_q, out_valid}, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = i[2:0];
      #10;
      check($sformatf("comb_%0d", i), {2'b00, carry, sum}, {2'b00, comb_tab[i]});
    end

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(1'b1, 3'b111);
    check("capture_111", {1'b0, sum_q, carry_q, out_valid}, 4'b0111);

    issue(1'b1, 3'b011);
    issue(1'b0, 3'b100);
    check("hold_regs", {1'b0, sum_q, carry_q, out_valid}, 4'b0010);
    check("hold_comb", {2'b00, sum, carry}, 4'b0010);

    issue(1'b1, 3'b111);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_reset_regs", {1'b0, sum_q, carry_q, out_valid}, 4'b0000);
    check("async_reset_comb", {2'b00, sum, carry}, 4'b0011);

    @(posedge clk);
    #1;
    check("reset_held", {1'b0, sum_q, carry_q, out_valid}, 4'b0000);
    {a, b, cin} = 3'b101;
    in_valid = 1'b1;
    exp_q.push_back(2'b10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_capture", {1'b0, sum_q, carry_q, out_valid}, 4'b0011);

    issue(1'b1, 3'b001);
    check("b2b_001", {1'b0, sum_q, carry_q, out_valid}, 4'b0101);
    issue(1'b1, 3'b110);
    check("b2b_110", {1'b0, sum_q, carry_q, out_valid}, 4'b0011);
    issue(1'b1, 3'b000);
    check("b2b_000", {1'b0, sum_q, carry_q, out_valid}, 4'b0001);
    issue(1'b0, 3'b000);
    issue(1'b0, 3'b000);

    check("scoreboard_drained", exp_q.size() > 15 ? 4'hf : 4'(exp_q.size()), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
